// File: rtl/gpio_counter_pkg.sv
// Shared definitions for the GPIO counter bank: control-register layout,
// register-select encoding and the control reset value.
package gpio_counter_pkg;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_DIR = 1;
    localparam int CTRL_SAT = 2;
    localparam int CTRL_OVF = 3;
    localparam int CTRL_W   = 4;

    // Register select is the MSB of the pad address.
    localparam logic REG_COUNT = 1'b0;
    localparam logic REG_CTRL  = 1'b1;

    // Field order matches the read-back layout {ovf, sat, dir, en}.
    typedef struct packed {
        logic ovf;
        logic sat;
        logic dir;
        logic en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = ctrl_t'(4'b0001);

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchroniser for asynchronous pad inputs; reset value is a
// parameter so idle-high strobes come out of reset inactive.
module pad_sync #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_counter_bank.sv
// Bank of CHANNELS independent WIDTH-bit counters behind one asynchronous
// pad strobe bus. Writes commit on the rising edge of the synced write
// strobe; reads snapshot the selected register on the falling edge of the
// synced output enable and hold it for the whole read.
module gpio_counter_bank
    import gpio_counter_pkg::*;
#(
    parameter int WIDTH    = 34,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = ((CHANNELS > 1) ? $clog2(CHANNELS) : 1) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              web_i,
    input  logic              oeb_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              data_oe_o
);

    localparam int                CH_W    = ADDR_W - 1;
    localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [CH_W:0]     NCH     = (CH_W + 1)'(CHANNELS);

    // ---------------------------------------------------------------
    // Pad synchronisers
    // ---------------------------------------------------------------
    logic              web_s;
    logic              oeb_s;
    logic [ADDR_W-1:0] addr_s;
    logic [WIDTH-1:0]  data_s;

    pad_sync #(.W(1), .RST_VAL(1'b1)) u_sync_web (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(web_i), .q_o(web_s)
    );
    pad_sync #(.W(1), .RST_VAL(1'b1)) u_sync_oeb (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(oeb_i), .q_o(oeb_s)
    );
    pad_sync #(.W(ADDR_W), .RST_VAL('0)) u_sync_addr (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(addr_i), .q_o(addr_s)
    );
    pad_sync #(.W(WIDTH), .RST_VAL('0)) u_sync_data (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(data_i), .q_o(data_s)
    );

    // ---------------------------------------------------------------
    // Edge detection and write capture
    // ---------------------------------------------------------------
    logic              web_prev_q;
    logic              oeb_prev_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [WIDTH-1:0]  cap_data_q;

    // Strobe history for edge detect; capture bus every cycle the write is low
    // so the commit uses the values from the last low cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            web_prev_q <= 1'b1;
            oeb_prev_q <= 1'b1;
            cap_addr_q <= '0;
            cap_data_q <= '0;
        end else begin
            web_prev_q <= web_s;
            oeb_prev_q <= oeb_s;
            if (!web_s) begin
                cap_addr_q <= addr_s;
                cap_data_q <= data_s;
            end
        end
    end

    logic            commit;
    logic            commit_ok;
    logic            cap_sel;
    logic [CH_W-1:0] cap_ch;
    logic            snap_en;

    assign cap_sel   = cap_addr_q[ADDR_W-1];
    assign cap_ch    = cap_addr_q[CH_W-1:0];
    assign commit    = web_s & ~web_prev_q;
    assign commit_ok = commit && ({1'b0, cap_ch} < NCH);
    // A read that starts while a write is in progress is ignored.
    assign snap_en   = ~oeb_s & oeb_prev_q & web_s;

    // ---------------------------------------------------------------
    // Prescaler
    // ---------------------------------------------------------------
    logic tick;

    if (PRESCALE > 1) begin : g_ps
        localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
        logic [PS_W-1:0] ps_q;
        logic [PS_W-1:0] ps_d;

        assign tick = (ps_q == PS_LAST);
        assign ps_d = tick ? '0 : ps_q + PS_W'(1);

        // Free-running divider, restarts from 0 after each tick.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) ps_q <= '0;
            else       ps_q <= ps_d;
        end
    end else begin : g_nops
        assign tick = 1'b1;
    end

    // ---------------------------------------------------------------
    // Per-channel counters
    // ---------------------------------------------------------------
    logic  [CHANNELS-1:0][WIDTH-1:0] cnt_vec;
    ctrl_t [CHANNELS-1:0]            ctrl_vec;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        ctrl_t            ctrl_q;
        ctrl_t            ctrl_d;
        logic             wr_hit;
        logic             at_lim;

        assign wr_hit = commit_ok && (cap_ch == CH_W'(c));

        // A write to this channel takes precedence over the step in the same cycle.
        always_comb begin
            cnt_d  = cnt_q;
            ctrl_d = ctrl_q;
            at_lim = ctrl_q.dir ? (cnt_q == '0) : (cnt_q == CNT_MAX);
            if (wr_hit) begin
                if (cap_sel == REG_COUNT) begin
                    cnt_d = cap_data_q;
                end else begin
                    ctrl_d.en  = cap_data_q[CTRL_EN];
                    ctrl_d.dir = cap_data_q[CTRL_DIR];
                    ctrl_d.sat = cap_data_q[CTRL_SAT];
                    ctrl_d.ovf = 1'b0;
                end
            end else if (tick && ctrl_q.en) begin
                if (at_lim) begin
                    ctrl_d.ovf = 1'b1;
                    if (!ctrl_q.sat) cnt_d = ctrl_q.dir ? CNT_MAX : '0;
                end else begin
                    cnt_d = ctrl_q.dir ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
                end
            end
        end

        // Counter and control state.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                ctrl_q <= CTRL_RST;
            end else begin
                cnt_q  <= cnt_d;
                ctrl_q <= ctrl_d;
            end
        end

        assign cnt_vec[c]  = cnt_q;
        assign ctrl_vec[c] = ctrl_q;
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] data_q;

    // Select the addressed register; unimplemented channels read as zero.
    always_comb begin
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr_s[CH_W-1:0] == CH_W'(c)) begin
                rd_val = (addr_s[ADDR_W-1] == REG_CTRL)
                       ? {{(WIDTH - CTRL_W){1'b0}}, ctrl_vec[c]}
                       : cnt_vec[c];
            end
        end
    end

    // Snapshot on read start so the pad sees a stable value (pre-step).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        data_q <= '0;
        else if (snap_en) data_q <= rd_val;
    end

    assign data_o    = data_q;
    assign data_oe_o = ~oeb_s & web_s;

endmodule

// File: tb/tb_gpio_counter_bank.sv
module tb_gpio_counter_bank;

    localparam int          W   = 34;
    localparam logic [63:0] MAX = 64'h3_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         web [2];
    logic         oeb [2];
    logic [2:0]   addr0;
    logic [3:0]   addr1;
    logic [W-1:0] din [2];
    logic [W-1:0] dout0, dout1;
    logic         oe0, oe1;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut 0: 4 channels, step every cycle
    gpio_counter_bank #(.WIDTH(W), .CHANNELS(4), .PRESCALE(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .web_i(web[0]), .oeb_i(oeb[0]),
        .addr_i(addr0), .data_i(din[0]), .data_o(dout0), .data_oe_o(oe0)
    );

    // dut 1: 5 channels (so channels 5..7 are unimplemented), step every 4 cycles
    gpio_counter_bank #(.WIDTH(W), .CHANNELS(5), .PRESCALE(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .web_i(web[1]), .oeb_i(oeb[1]),
        .addr_i(addr1), .data_i(din[1]), .data_o(dout1), .data_oe_o(oe1)
    );

    // Reference model: each channel is a base value loaded at cycle mk plus
    // the number of prescaler ticks elapsed since, applied arithmetically.
    logic [63:0] mv   [2][8];
    int          mk   [2][8];
    bit          men  [2][8];
    bit          mdir [2][8];
    bit          msat [2][8];
    bit          movf [2][8];
    int          R0;
    logic [63:0] last_snap [2];

    function automatic int nch(input int d); return (d == 0) ? 4 : 5; endfunction
    function automatic int ps(input int d);  return (d == 0) ? 1 : 4; endfunction

    function automatic logic [63:0] get_dout(input int d);
        return (d == 0) ? 64'(dout0) : 64'(dout1);
    endfunction
    function automatic logic [63:0] get_oe(input int d);
        return (d == 0) ? 64'(oe0) : 64'(oe1);
    endfunction

    // State of a channel after posedge m (m >= mk).
    function automatic void eval(input int d, input int ch, input int m,
                                 output logic [63:0] v, output bit o);
        int          n;
        logic [63:0] n64;
        n   = (m - R0) / ps(d) - (mk[d][ch] - R0) / ps(d);
        n64 = 64'(n);
        v   = mv[d][ch];
        o   = movf[d][ch];
        if (men[d][ch] && n > 0) begin
            if (!mdir[d][ch]) begin
                if (v + n64 > MAX) begin
                    o = 1'b1;
                    v = msat[d][ch] ? MAX : ((v + n64) & MAX);
                end else v = v + n64;
            end else begin
                if (n64 > v) begin
                    o = 1'b1;
                    v = msat[d][ch] ? 64'd0 : ((v - n64) & MAX);
                end else v = v - n64;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            last_snap[d] = 64'd0;
            for (int ch = 0; ch < 8; ch++) begin
                mv[d][ch] = 64'd0; mk[d][ch] = R0; men[d][ch] = 1'b1;
                mdir[d][ch] = 1'b0; msat[d][ch] = 1'b0; movf[d][ch] = 1'b0;
            end
        end
    endfunction

    // Write landing at posedge k: replaces whatever the step at k would have done.
    function automatic void model_commit(input int d, input bit sel, input int ch,
                                         input logic [W-1:0] data, input int k);
        logic [63:0] v;
        bit          o;
        if (ch >= nch(d)) return;
        eval(d, ch, k - 1, v, o);
        if (!sel) begin
            mv[d][ch] = 64'(data); movf[d][ch] = o;
        end else begin
            mv[d][ch] = v; movf[d][ch] = 1'b0;
            men[d][ch] = data[0]; mdir[d][ch] = data[1]; msat[d][ch] = data[2];
        end
        mk[d][ch] = k;
    endfunction

    function automatic logic [63:0] exp_read(input int d, input bit sel, input int ch, input int m);
        logic [63:0] v;
        bit          o;
        if (ch >= nch(d)) return 64'd0;
        eval(d, ch, m, v, o);
        return sel ? 64'({o, msat[d][ch], mdir[d][ch], men[d][ch]}) : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit w, input bit oe, input bit sel,
                         input int ch, input logic [W-1:0] data);
        web[d] = w;
        oeb[d] = oe;
        din[d] = data;
        if (d == 0) addr0 = {sel, 2'(ch)};
        else        addr1 = {sel, 3'(ch)};
    endtask

    // Hold web low for len cycles; with both set, oeb is held low alongside.
    task automatic do_write(input int d, input bit sel, input int ch,
                            input logic [W-1:0] data, input int len, input bit both);
        int c;
        @(negedge clk);
        drive(d, 1'b0, !both, sel, ch, data);
        repeat (len) @(negedge clk);
        if (both) begin
            check("both_low_oe", get_oe(d), 64'd0);
            check("both_low_hold", get_dout(d), last_snap[d]);
        end
        c = cyc;
        web[d] = 1'b1;
        oeb[d] = 1'b1;
        repeat (3) @(negedge clk);
        model_commit(d, sel, ch, data, c + 3);
    endtask

    task automatic do_read(input int d, input bit sel, input int ch, input string tag,
                           output logic [63:0] obs);
        int          r;
        logic [63:0] e;
        @(negedge clk);
        r = cyc;
        drive(d, 1'b1, 1'b0, sel, ch, din[d]);
        repeat (3) @(negedge clk);
        e   = exp_read(d, sel, ch, r + 2);
        obs = get_dout(d);
        check({tag, "_data"}, obs, e);
        check({tag, "_oe"}, get_oe(d), 64'd1);
        last_snap[d] = e;
        oeb[d] = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_oe_off"}, get_oe(d), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d0"},  64'(dout0), 64'd0);
        check({tag, "_oe0"}, 64'(oe0),   64'd0);
        check({tag, "_d1"},  64'(dout1), 64'd0);
        check({tag, "_oe1"}, 64'(oe1),   64'd0);
    endtask

    initial begin
        logic [63:0] obs;
        int          d, ch, op, len;
        logic [W-1:0] v;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(i, 1'b1, 1'b1, 1'b0, 0, '0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        R0 = cyc;
        model_reset();

        // free-running counts after reset
        do_read(0, 1'b0, 0, "rst_ch0", obs);
        check("rst_ch0_direct", obs, 64'd3);
        for (int i = 1; i < 4; i++) do_read(0, 1'b0, i, "rst_cnt", obs);
        do_read(0, 1'b1, 0, "rst_ctrl", obs);
        check("rst_ctrl_direct", obs, 64'h1);

        // up-wrap through max sets ovf, other channels untouched
        do_write(0, 1'b0, 2, 34'h3_FFFF_FFFE, 3, 1'b0);
        do_read(0, 1'b1, 2, "wrap_ctrl", obs);
        check("wrap_ctrl_direct", obs, 64'h9);
        do_read(0, 1'b0, 2, "wrap_cnt", obs);
        for (int i = 0; i < 4; i++) if (i != 2) do_read(0, 1'b0, i, "wrap_other", obs);

        // down-saturate at zero, then ctrl rewrite clears ovf
        do_write(0, 1'b1, 1, 34'h7, 1, 1'b0);
        do_write(0, 1'b0, 1, 34'h1, 1, 1'b0);
        do_read(0, 1'b1, 1, "sat_ctrl", obs);
        check("sat_ctrl_direct", obs, 64'hF);
        do_read(0, 1'b0, 1, "sat_cnt", obs);
        check("sat_cnt_direct", obs, 64'h0);
        do_write(0, 1'b1, 1, 34'h6, 2, 1'b0);
        do_read(0, 1'b1, 1, "ovf_clr", obs);
        check("ovf_clr_direct", obs, 64'h6);

        // disabled channel stays frozen
        do_write(0, 1'b1, 3, 34'h0, 1, 1'b0);
        do_read(0, 1'b0, 3, "frz_a", obs);
        repeat (100) @(negedge clk);
        do_read(0, 1'b0, 3, "frz_b", obs);

        // web and oeb low together: a write, no snapshot and no drive
        do_write(0, 1'b0, 0, 34'h55, 4, 1'b1);
        do_read(0, 1'b0, 0, "both_cnt", obs);

        // prescaled bank: unimplemented channel writes dropped and read 0
        do_write(1, 1'b0, 6, 34'h1234, 2, 1'b0);
        do_write(1, 1'b1, 5, 34'h0, 2, 1'b0);
        do_read(1, 1'b0, 6, "bad_cnt", obs);
        check("bad_cnt_direct", obs, 64'd0);
        do_read(1, 1'b1, 5, "bad_ctrl", obs);
        for (int i = 0; i < 5; i++) do_read(1, 1'b0, i, "ps_cnt", obs);
        repeat (20) @(negedge clk);
        do_read(1, 1'b0, 0, "ps_adv", obs);

        // write landing on a tick loads the value with no step
        while (((cyc + 5 - R0) % 4) != 0) @(negedge clk);
        do_write(1, 1'b0, 4, 34'h123, 1, 1'b0);
        do_read(1, 1'b0, 4, "tick_wr", obs);
        check("tick_wr_direct", obs, 64'h123);

        // randomised mix of writes and reads across both banks
        for (int i = 0; i < 60; i++) begin
            d   = $urandom_range(0, 1);
            ch  = $urandom_range(0, (d == 0) ? 3 : 7);
            op  = $urandom_range(0, 3);
            len = $urandom_range(1, 3);
            case ($urandom_range(0, 4))
                0:       v = '0;
                1:       v = W'(1);
                2:       v = W'(MAX - 64'd1);
                3:       v = W'(MAX);
                default: v = {2'($urandom_range(0, 3)), 32'($urandom)};
            endcase
            case (op)
                0: do_write(d, 1'b0, ch, v, len, 1'b0);
                1: do_write(d, 1'b1, ch, v, len, 1'b0);
                2: do_read(d, 1'b0, ch, "rnd_cnt", obs);
                default: do_read(d, 1'b1, ch, "rnd_ctrl", obs);
            endcase
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end

        // reset in the middle of a write: nothing commits afterwards
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 1'b0, 0, 34'h2AAAA);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        web[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        R0 = cyc;
        model_reset();
        repeat (5) @(negedge clk);
        check("midrst_oe_idle", 64'(oe0), 64'd0);
        do_read(0, 1'b0, 0, "midrst_cnt", obs);
        do_read(0, 1'b1, 0, "midrst_ctrl", obs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
